// File: rtl/sd_pkg.sv
// Shared constants for the MASH sigma-delta modulator: output width, dither LFSR
// parameters and noise-shaping mode encodings.
package sd_pkg;

   localparam int Y_W = 3;

   localparam int MODE_FIRST  = 0;
   localparam int MODE_MASH11 = 1;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] state);
      return {^(state & LFSR_TAPS), state[15:1]};
   endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// One first-order accumulator stage: registered phase accumulator whose
// wrap-around carry is the stage's 1-bit quantised output.
module mash_acc_stage #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce_i,
   input  logic         clr_i,
   input  logic [W-1:0] addend_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         carry_o
);

   logic [W-1:0] acc_q, acc_d;

   assign {carry_o, sum_o} = {1'b0, acc_q} + {1'b0, addend_i} + {{W{1'b0}}, cin_i};

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (ce_i) begin
         acc_d = sum_o;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/mash_sd_modulator.sv
// MASH 1-1 / first-order sigma-delta modulator with optional stage-2 LFSR dither,
// clock-enable tick and input holding register.
module mash_sd_modulator
   import sd_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int MODE   = MODE_MASH11,
   parameter int DITHER = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  clr,
   input  logic                  x_valid,
   input  logic [IN_W-1:0]       x,
   output logic signed [Y_W-1:0] y,
   output logic                  y_valid
);

   logic [IN_W-1:0]       xh_q;
   logic [IN_W-1:0]       s1;
   logic                  c1;
   logic signed [Y_W-1:0] shaped;
   logic signed [Y_W-1:0] y_q, y_d;
   logic                  y_valid_q, y_valid_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xh_q <= '0;
      end else if (x_valid) begin
         xh_q <= x;
      end
   end

   mash_acc_stage #(.W(IN_W)) u_stage1 (
      .clk      (clk),
      .rst      (rst),
      .ce_i     (ce),
      .clr_i    (clr),
      .addend_i (xh_q),
      .cin_i    (1'b0),
      .sum_o    (s1),
      .carry_o  (c1)
   );

   if (MODE == MODE_MASH11) begin : g_mash
      logic [IN_W-1:0] s2_unused;
      logic            c2;
      logic            c2_dly_q;
      logic            dither_bit;

      if (DITHER != 0) begin : g_dither
         logic [15:0] lfsr_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lfsr_q <= LFSR_SEED;
            end else if (clr) begin
               lfsr_q <= LFSR_SEED;
            end else if (ce) begin
               lfsr_q <= lfsr_next(lfsr_q);
            end
         end

         assign dither_bit = lfsr_q[0];
      end else begin : g_no_dither
         assign dither_bit = 1'b0;
      end

      // Stage 2 re-quantises stage 1's residue; only its carry is used.
      mash_acc_stage #(.W(IN_W)) u_stage2 (
         .clk      (clk),
         .rst      (rst),
         .ce_i     (ce),
         .clr_i    (clr),
         .addend_i (s1),
         .cin_i    (dither_bit),
         .sum_o    (s2_unused),
         .carry_o  (c2)
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            c2_dly_q <= 1'b0;
         end else if (clr) begin
            c2_dly_q <= 1'b0;
         end else if (ce) begin
            c2_dly_q <= c2;
         end
      end

      // c1 + (1 - z^-1) c2: range -1..+2.
      assign shaped = $signed({{(Y_W-1){1'b0}}, c1})
                    + $signed({{(Y_W-1){1'b0}}, c2})
                    - $signed({{(Y_W-1){1'b0}}, c2_dly_q});
   end else begin : g_first
      assign shaped = {{(Y_W-1){1'b0}}, c1};
   end

   always_comb begin
      y_d       = y_q;
      y_valid_d = 1'b0;
      if (clr) begin
         y_d = '0;
      end else if (ce) begin
         y_d       = shaped;
         y_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign y       = y_q;
   assign y_valid = y_valid_q;

endmodule
